stream_demux1x2: RTL and testbench

STREAM_DEMUX1X2 -- requirements
Module: stream_demux1x2

---
 rtl/demux_pkg.sv | 17 +
 rtl/stream_reg.sv | 50 +++++
 rtl/stream_demux1x2.sv | 81 ++++++++
 tb/tb_stream_demux1x2.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer and its per-channel register.
package demux_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } reg_state_e;

endpackage

// File: rtl/stream_reg.sv
// One-entry valid/ready register: holds a single word, loads and drains on the same edge
// for full throughput.
module stream_reg
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  can_load,
  output logic                  xfer
);

  reg_state_e state, state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Data only changes on a load, so a drain without a load keeps the last word visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

  always_comb begin
    state_next = state;
    valid      = (state == ST_FULL);
    xfer       = valid && ready;
    can_load   = !valid || ready;
    case (state)
      ST_EMPTY: if (load)           state_next = ST_FULL;
      ST_FULL:  if (ready && !load) state_next = ST_EMPTY;
      default:                      state_next = ST_EMPTY;
    endcase
  end

endmodule

// File: rtl/stream_demux1x2.sv
// Routes one valid/ready input stream to output A or B via two independent one-entry buffers.
// Define STREAM_DEMUX_CNT_EN to add per-channel completed-transfer counters cnt_a/cnt_b.
module stream_demux1x2
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_a_data,
  output logic                  out_a_valid,
  input  logic                  out_a_ready,
  output logic [DATA_WIDTH-1:0] out_b_data,
  output logic                  out_b_valid,
  input  logic                  out_b_ready
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt_a,
  output logic [CNT_WIDTH-1:0]  cnt_b
`endif
);

  logic a_can_load, b_can_load;
  logic a_xfer, b_xfer;
  logic load_a, load_b;
  logic to_b;

  // Readiness depends only on the addressed channel, so a stalled channel never blocks the other.
  always_comb begin
    to_b     = (sel_e'(in_sel) == SEL_B);
    in_ready = to_b ? b_can_load : a_can_load;
    load_a   = in_valid && in_ready && !to_b;
    load_b   = in_valid && in_ready && to_b;
  end

  stream_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg_a (
    .clk      (clk),
    .reset    (reset),
    .load     (load_a),
    .load_data(in_data),
    .ready    (out_a_ready),
    .valid    (out_a_valid),
    .data     (out_a_data),
    .can_load (a_can_load),
    .xfer     (a_xfer)
  );

  stream_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg_b (
    .clk      (clk),
    .reset    (reset),
    .load     (load_b),
    .load_data(in_data),
    .ready    (out_b_ready),
    .valid    (out_b_valid),
    .data     (out_b_data),
    .can_load (b_can_load),
    .xfer     (b_xfer)
  );

`ifdef STREAM_DEMUX_CNT_EN
  // Counters wrap naturally; reset wins over a transfer on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_xfer) cnt_a <= cnt_a + CNT_WIDTH'(1);
      if (b_xfer) cnt_b <= cnt_b + CNT_WIDTH'(1);
    end
  end
`else
  logic unused_xfer;
  assign unused_xfer = a_xfer ^ b_xfer;
`endif

endmodule

// File: tb/tb_stream_demux1x2.sv
// Scoreboard bench for stream_demux1x2: accepted words are queued per channel and a
// negedge monitor checks every output transfer against them.
module tb_stream_demux1x2;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_a_data, out_b_data;
  logic          out_a_valid, out_b_valid;
  logic          out_a_ready = 1'b0;
  logic          out_b_ready = 1'b0;
`ifdef STREAM_DEMUX_CNT_EN
  logic [CW-1:0] cnt_a, cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  stream_demux1x2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_a_data (out_a_data),
    .out_a_valid(out_a_valid),
    .out_a_ready(out_a_ready),
    .out_b_data (out_b_data),
    .out_b_valid(out_b_valid),
    .out_b_ready(out_b_ready)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a transfer happens on the coming edge whenever valid && ready is seen here.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_a_valid && out_a_ready) begin
        if (qa.size() == 0) checkOutput("a_unexpected_word", {24'd0, out_a_data}, 32'hFFFF_FFFF);
        else checkOutput("a_order", {24'd0, out_a_data}, {24'd0, qa.pop_front()});
      end
      if (out_b_valid && out_b_ready) begin
        if (qb.size() == 0) checkOutput("b_unexpected_word", {24'd0, out_b_data}, 32'hFFFF_FFFF);
        else checkOutput("b_order", {24'd0, out_b_data}, {24'd0, qb.pop_front()});
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    in_valid = 1'b0;
    idle();
    reset = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  // Offer one word for a single cycle; exp_acc is the hand-derived in_ready for this cycle.
  task automatic applyStimulus(input logic sel, input logic [DW-1:0] d, input logic exp_acc);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    #1;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
    if (exp_acc) begin
      if (sel) qb.push_back(d);
      else     qa.push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hEE;
    in_sel   = ~sel;
  endtask

  task automatic checkChannels(input string name, input logic va, input logic [DW-1:0] da,
                               input logic vb, input logic [DW-1:0] db);
    checkOutput({name, "_a_valid"}, {31'd0, out_a_valid}, {31'd0, va});
    checkOutput({name, "_a_data"},  {24'd0, out_a_data},  {24'd0, da});
    checkOutput({name, "_b_valid"}, {31'd0, out_b_valid}, {31'd0, vb});
    checkOutput({name, "_b_data"},  {24'd0, out_b_data},  {24'd0, db});
  endtask

  task automatic checkReadyBoth(input string name);
    in_sel = 1'b0; #1;
    checkOutput({name, "_ready_sel0"}, {31'd0, in_ready}, 32'd1);
    in_sel = 1'b1; #1;
    checkOutput({name, "_ready_sel1"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle();
    doReset();
    checkChannels("reset", 1'b0, 8'h00, 1'b0, 8'h00);
    checkReadyBoth("reset");

    // Single word to A, one-cycle latency, B untouched.
    out_a_ready = 1'b1;
    out_b_ready = 1'b0;
    applyStimulus(1'b0, 8'hA5, 1'b1);
    checkChannels("first", 1'b1, 8'hA5, 1'b0, 8'h00);
    idle();

    // Stalled B blocks only B traffic.
    applyStimulus(1'b1, 8'h3C, 1'b1);
    applyStimulus(1'b1, 8'h7E, 1'b0);
    checkOutput("b_hold_valid", {31'd0, out_b_valid}, 32'd1);
    checkOutput("b_hold_data", {24'd0, out_b_data}, 32'h3C);
    applyStimulus(1'b0, 8'h11, 1'b1);
    checkOutput("a_past_stall", {24'd0, out_a_data}, 32'h11);
    out_b_ready = 1'b1;
    idle();
    checkOutput("b_drain_valid", {31'd0, out_b_valid}, 32'd0);
    checkOutput("b_drain_keeps_data", {24'd0, out_b_data}, 32'h3C);

    // Back-to-back alternating words at full rate.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0], 8'h10 + 8'(i), 1'b1);
      if (i[0]) checkOutput("b2b_b_data", {24'd0, out_b_data}, 32'h10 + i);
      else      checkOutput("b2b_a_data", {24'd0, out_a_data}, 32'h10 + i);
    end
    idle();
    checkChannels("b2b_end", 1'b0, 8'h18, 1'b0, 8'h19);

    // Drain and reload A on the same edge.
    out_a_ready = 1'b0;
    applyStimulus(1'b0, 8'h22, 1'b1);
    out_a_ready = 1'b1;
    applyStimulus(1'b0, 8'h55, 1'b1);
    checkOutput("reload_valid", {31'd0, out_a_valid}, 32'd1);
    checkOutput("reload_data", {24'd0, out_a_data}, 32'h55);
    idle();

    // Reset with both channels full discards the words.
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    applyStimulus(1'b0, 8'h66, 1'b1);
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkChannels("full", 1'b1, 8'h66, 1'b1, 8'h77);
    doReset();
    checkChannels("midreset", 1'b0, 8'h00, 1'b0, 8'h00);
    checkReadyBoth("midreset");
`ifdef STREAM_DEMUX_CNT_EN
    checkOutput("cnt_a_reset", {28'd0, cnt_a}, 32'd0);
    checkOutput("cnt_b_reset", {28'd0, cnt_b}, 32'd0);
`endif

    // 17 transfers on A: a 4-bit counter wraps to 1.
    out_a_ready = 1'b1;
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 8'hC0 + 8'(i), 1'b1);
    idle();
    checkOutput("a_empty_after_17", {31'd0, out_a_valid}, 32'd0);
`ifdef STREAM_DEMUX_CNT_EN
    checkOutput("cnt_a_wrap", {28'd0, cnt_a}, 32'd1);
    checkOutput("cnt_b_zero", {28'd0, cnt_b}, 32'd0);
`endif

    idle();
    checkOutput("qa_drained", qa.size(), 32'd0);
    checkOutput("qb_drained", qb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
